life_controller: RTL and testbench
==================================

// Module: life_controller
// PURPOSE
//   Owns the player lives counter and sequences each collision event: decrement
//   lives, hold the collision flag for a respawn delay, pulse a player respawn,
//   then grant a timed invulnerability window. Drives i_Collision/i_Lives of the
//   game state FSM and consumes its o_Game_State. Sits between the sprite overlap
//   detector (raw hit) and the game state FSM; timing is in video frame ticks.
// PARAMETERS
//   START_LIVES    3   lives loaded at reset / new game (1..2^LIVES_W-1)
//   LIVES_W        4   width of lives counter
//   RESPAWN_FRAMES 30  frame ticks o_Collision is held after a hit (>=1)
//   INVULN_FRAMES  60  frame ticks of invulnerability after respawn (0 = none)
//   TIMER_W        8   frame timer width; must hold max(RESPAWN,INVULN)_FRAMES
// PORTS
//   i_Clk             in   1        system clock
//   i_Reset           in   1        reset, asynchronous, active-high
//   i_Frame_Tick      in   1        1-cycle pulse per video frame
//   i_Game_State      in   2        00 IDLE, 01 RUN, 10 WIN, 11 CLEAN
//   i_Hit             in   1        raw player/obstacle overlap, level
//   o_Lives           out  LIVES_W  remaining lives
//   o_Collision       out  1        collision flag to game state FSM
//   o_Player_Respawn  out  1        1-cycle pulse: return player to spawn
//   o_Invulnerable    out  1        high during invulnerability window
//   o_Game_Over       out  1        high once lives reach 0
// BEHAVIOUR
//   Reset (async): state S_IDLE, o_Lives=START_LIVES, timer=0, all flags 0.
//   All outputs registered. States: S_IDLE, S_ALIVE, S_RESPAWN, S_INVULN, S_OVER.
//   S_IDLE: lives=START_LIVES, flags 0; i_Game_State==RUN -> S_ALIVE.
//   S_ALIVE: i_Hit=1 and i_Game_State==RUN sampled at edge N ->
//     at N+1 o_Lives=old-1 (saturate at 0), timer=0;
//     new lives>0: o_Collision=1, -> S_RESPAWN;
//     new lives==0: o_Game_Over=1, o_Collision=0, -> S_OVER.
//   S_RESPAWN: timer++ per i_Frame_Tick; on the tick where timer==RESPAWN_FRAMES-1:
//     o_Collision<=0, o_Player_Respawn<=1 (exactly one cycle), timer<=0,
//     INVULN_FRAMES>0: o_Invulnerable<=1, -> S_INVULN; else -> S_ALIVE.
//   S_INVULN: i_Hit ignored; timer++ per tick; on tick where
//     timer==INVULN_FRAMES-1: o_Invulnerable<=0, -> S_ALIVE.
//   S_OVER: o_Lives=0, o_Game_Over=1 held; i_Game_State==RUN (new game) ->
//     o_Lives=START_LIVES, o_Game_Over=0, -> S_ALIVE.
//   i_Game_State==IDLE while in ALIVE/RESPAWN/INVULN -> S_IDLE next edge,
//     lives reloaded, all flags cleared (abort mid-sequence).
//   i_Game_State==WIN: hits ignored, timer frozen, outputs held (except
//     o_Player_Respawn forced 0); resumes where left off when state returns.
//   i_Hit in S_RESPAWN/S_INVULN/S_OVER/S_IDLE: ignored, no decrement.
//   i_Hit held high across multiple cycles: exactly one decrement per event;
//     a new hit is accepted only after re-entering S_ALIVE.
//   i_Hit and i_Frame_Tick same cycle in S_ALIVE: hit processed; tick unused.
//   Timer compare uses TIMER_W-bit unsigned; never wraps within a phase.
//   i_Reset mid-sequence: immediate return to reset values, no respawn pulse.
// TESTING
//   Reset, Game_State=RUN, Hit 1 cycle -> next edge Lives=2, Collision=1.
//   Continue: after 30 Frame_Ticks -> Collision=0, Respawn pulse 1 cycle,
//     Invulnerable=1; Hit during next 60 ticks -> Lives stays 2.
//   Three separated hits from 3 lives -> Lives=0, Game_Over=1, Collision=0
//     on third; Game_State=RUN afterwards -> Lives=3, Game_Over=0.
//   Hit held 100 cycles in ALIVE -> exactly one decrement.
//   In S_RESPAWN, Game_State=WIN for 10 ticks -> timer frozen, Collision held;
//     Game_State=IDLE mid-RESPAWN -> Lives=3, all flags 0.
//   Assert i_Reset mid-INVULN -> outputs reset asynchronously, no Respawn pulse.

Source files
------------

// File: rtl/life_controller.sv
// Player lives counter and collision sequencer: hit -> respawn delay ->
// respawn pulse -> invulnerability window, paced by video frame ticks.
module life_controller #(
  parameter int START_LIVES    = 3,
  parameter int LIVES_W        = 4,
  parameter int RESPAWN_FRAMES = 30,
  parameter int INVULN_FRAMES  = 60,
  parameter int TIMER_W        = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Frame_Tick,
  input  logic [1:0]         i_Game_State,
  input  logic               i_Hit,
  output logic [LIVES_W-1:0] o_Lives,
  output logic               o_Collision,
  output logic               o_Player_Respawn,
  output logic               o_Invulnerable,
  output logic               o_Game_Over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIVE,
    S_RESPAWN,
    S_INVULN,
    S_OVER
  } state_e;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;
  localparam logic [1:0] GS_WIN  = 2'b10;

  localparam logic [LIVES_W-1:0] START =
    LIVES_W'(START_LIVES);
  localparam logic [TIMER_W-1:0] RESP_LAST =
    TIMER_W'(RESPAWN_FRAMES - 1);
  localparam int INV_LAST_I =
    (INVULN_FRAMES > 0) ? INVULN_FRAMES - 1 : 0;
  localparam logic [TIMER_W-1:0] INV_LAST =
    TIMER_W'(INV_LAST_I);

  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 coll_q, coll_d;
  logic                 resp_q, resp_d;
  logic                 inv_q, inv_d;
  logic                 over_q, over_d;
  logic [LIVES_W-1:0]   lives_dec;
  logic                 gs_run, gs_win, gs_idle;

  assign gs_run  = (i_Game_State == GS_RUN);
  assign gs_win  = (i_Game_State == GS_WIN);
  assign gs_idle = (i_Game_State == GS_IDLE);

  assign lives_dec = (lives_q == '0) ? '0
                   : lives_q - LIVES_W'(1);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      lives_q <= START;
      timer_q <= '0;
      coll_q  <= 1'b0;
      resp_q  <= 1'b0;
      inv_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      timer_q <= timer_d;
      coll_q  <= coll_d;
      resp_q  <= resp_d;
      inv_q   <= inv_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    timer_d = timer_q;
    coll_d  = coll_q;
    resp_d  = 1'b0;
    inv_d   = inv_q;
    over_d  = over_q;
    case (state_q)
      S_IDLE: begin
        lives_d = START;
        timer_d = '0;
        coll_d  = 1'b0;
        inv_d   = 1'b0;
        over_d  = 1'b0;
        if (gs_run) state_d = S_ALIVE;
      end
      S_ALIVE: begin
        if (gs_idle) begin
          state_d = S_IDLE;
          lives_d = START;
          timer_d = '0;
          coll_d  = 1'b0;
          inv_d   = 1'b0;
          over_d  = 1'b0;
        end else if (i_Hit && gs_run) begin
          lives_d = lives_dec;
          timer_d = '0;
          if (lives_dec != '0) begin
            coll_d  = 1'b1;
            state_d = S_RESPAWN;
          end else begin
            coll_d  = 1'b0;
            over_d  = 1'b1;
            state_d = S_OVER;
          end
        end
      end
      S_RESPAWN: begin
        if (gs_idle) begin
          state_d = S_IDLE;
          lives_d = START;
          timer_d = '0;
          coll_d  = 1'b0;
          inv_d   = 1'b0;
          over_d  = 1'b0;
        end else if (!gs_win && i_Frame_Tick) begin
          if (timer_q == RESP_LAST) begin
            coll_d  = 1'b0;
            resp_d  = 1'b1;
            timer_d = '0;
            if (INVULN_FRAMES > 0) begin
              inv_d   = 1'b1;
              state_d = S_INVULN;
            end else begin
              state_d = S_ALIVE;
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      S_INVULN: begin
        if (gs_idle) begin
          state_d = S_IDLE;
          lives_d = START;
          timer_d = '0;
          coll_d  = 1'b0;
          inv_d   = 1'b0;
          over_d  = 1'b0;
        end else if (!gs_win && i_Frame_Tick) begin
          if (timer_q == INV_LAST) begin
            inv_d   = 1'b0;
            timer_d = '0;
            state_d = S_ALIVE;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      S_OVER: begin
        lives_d = '0;
        over_d  = 1'b1;
        if (gs_run) begin
          lives_d = START;
          over_d  = 1'b0;
          timer_d = '0;
          state_d = S_ALIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_Lives          = lives_q;
  assign o_Collision      = coll_q;
  assign o_Player_Respawn = resp_q;
  assign o_Invulnerable   = inv_q;
  assign o_Game_Over      = over_q;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with default parameters
// (3 lives, 30 respawn frames, 60 invulnerability frames).
module tb_life_controller;

  logic       clk;
  logic       rst;
  logic       ft;
  logic [1:0] gs;
  logic       hit;
  logic [3:0] lives;
  logic       coll;
  logic       resp;
  logic       inv;
  logic       over;

  int checks;
  int failures;
  int resp_seen;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] WIN   = 2'b10;
  localparam logic [1:0] CLEAN = 2'b11;

  life_controller dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_Frame_Tick     (ft),
    .i_Game_State     (gs),
    .i_Hit            (hit),
    .o_Lives          (lives),
    .o_Collision      (coll),
    .o_Player_Respawn (resp),
    .o_Invulnerable   (inv),
    .o_Game_Over      (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (resp === 1'b1) resp_seen++;
  endtask

  task automatic tick();
    ft = 1'b1;
    cyc();
    ft = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resp_seen = 0;
    rst = 1'b1;
    ft  = 1'b0;
    gs  = IDLE;
    hit = 1'b0;
    cyc();
    cyc();
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_coll", 32'(coll), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_inv", 32'(inv), 32'd0);
    chk("rst_over", 32'(over), 32'd0);
    rst = 1'b0;
    cyc();

    // hit while idle is ignored
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("idle_hit_lives", 32'(lives), 32'd3);

    gs = RUN;
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("hit1_lives", 32'(lives), 32'd2);
    chk("hit1_coll", 32'(coll), 32'd1);

    ticks(29);
    chk("resp29_coll", 32'(coll), 32'd1);
    chk("resp29_pulse", 32'(resp), 32'd0);
    tick();
    chk("resp30_coll", 32'(coll), 32'd0);
    chk("resp30_pulse", 32'(resp), 32'd1);
    chk("resp30_inv", 32'(inv), 32'd1);
    cyc();
    chk("pulse_1cyc", 32'(resp), 32'd0);

    // hits ignored throughout invulnerability
    hit = 1'b1;
    ticks(59);
    hit = 1'b0;
    chk("inv_hit_lives", 32'(lives), 32'd2);
    chk("inv59_inv", 32'(inv), 32'd1);
    tick();
    chk("inv60_inv", 32'(inv), 32'd0);
    chk("inv60_lives", 32'(lives), 32'd2);

    // held hit -> single decrement
    hit = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    hit = 1'b0;
    chk("held_lives", 32'(lives), 32'd1);
    chk("held_coll", 32'(coll), 32'd1);

    // WIN freezes the respawn timer
    ticks(10);
    gs = WIN;
    ticks(10);
    chk("win_coll", 32'(coll), 32'd1);
    gs = RUN;
    ticks(19);
    chk("frozen_coll", 32'(coll), 32'd1);
    chk("frozen_inv", 32'(inv), 32'd0);
    tick();
    chk("unfrz_pulse", 32'(resp), 32'd1);
    chk("unfrz_inv", 32'(inv), 32'd1);

    // async reset mid-invulnerability
    ticks(5);
    resp_seen = 0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_inv", 32'(inv), 32'd0);
    chk("arst_lives", 32'(lives), 32'd3);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("arst_nopulse", 32'(resp_seen), 32'd0);

    // IDLE aborts mid-respawn
    gs = RUN;
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("abort_pre_lives", 32'(lives), 32'd2);
    ticks(5);
    gs = IDLE;
    cyc();
    chk("abort_lives", 32'(lives), 32'd3);
    chk("abort_coll", 32'(coll), 32'd0);
    chk("abort_inv", 32'(inv), 32'd0);

    // three hits to game over; hit2 coincides with a tick
    gs = RUN;
    cyc();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    ticks(90);
    chk("go1_lives", 32'(lives), 32'd2);
    hit = 1'b1;
    ft  = 1'b1;
    cyc();
    hit = 1'b0;
    ft  = 1'b0;
    chk("go2_lives", 32'(lives), 32'd1);
    ticks(29);
    chk("go2_t29_coll", 32'(coll), 32'd1);
    tick();
    chk("go2_t30_pulse", 32'(resp), 32'd1);
    ticks(60);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    gs  = CLEAN;
    chk("go3_lives", 32'(lives), 32'd0);
    chk("go3_over", 32'(over), 32'd1);
    chk("go3_coll", 32'(coll), 32'd0);
    cyc();
    chk("over_hold", 32'(over), 32'd1);
    gs = RUN;
    cyc();
    chk("newgame_lives", 32'(lives), 32'd3);
    chk("newgame_over", 32'(over), 32'd0);
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    chk("newgame_hit", 32'(lives), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
